// File: rtl/btn_intr_ctrl_pkg.sv
// Shared constants and FSM state types for the push-button interrupt controller.
// Register offsets are word indices (byte address bits [4:2]).
package btn_intr_ctrl_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] ADDR_COUNT   = 3'd2;
  localparam logic [2:0] ADDR_LEDSNAP = 3'd3;
  localparam logic [2:0] ADDR_TSTAMP  = 3'd4;

  localparam int unsigned ST_PEND_BIT = 0;
  localparam int unsigned ST_OVF_BIT  = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {WrIdle, WrAccept, WrResp} wr_state_e;
  typedef enum logic [1:0] {RdIdle, RdAccept, RdResp} rd_state_e;

endpackage

// File: rtl/btn_evt_cnt.sv
// Press-event edge detector, wrapping counter with sticky overflow and LED snapshot.
// Optional timestamp capture when BTN_TIMESTAMP_EN is defined.
module btn_evt_cnt
  import btn_intr_ctrl_pkg::*;
#(
  parameter int unsigned CntW = 16,
  parameter int unsigned TsW  = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            intr_src_i,
  input  logic [3:0]      led_on_i,
  input  logic            cnt_clr_i,
  input  logic            ovf_clr_i,
  output logic            evt_o,
  output logic [CntW-1:0] count_o,
  output logic            ovf_o,
  output logic [3:0]      led_snap_o,
  output logic [TsW-1:0]  tstamp_o
);

  logic            intr_q;
  logic [CntW-1:0] cnt_q;
  logic            ovf_q;
  logic [3:0]      led_q;
  logic            wrap;

  assign evt_o = intr_src_i & ~intr_q;
  // A clear in the same cycle restarts from zero, so it can never wrap.
  assign wrap  = evt_o & ~cnt_clr_i & (&cnt_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      intr_q <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      led_q  <= 4'h0;
    end else begin
      intr_q <= intr_src_i;
      if (cnt_clr_i) begin
        cnt_q <= evt_o ? CntW'(1) : '0;
      end else if (evt_o) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (wrap) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_q <= 1'b0;
      end
      if (evt_o) begin
        led_q <= led_on_i;
      end
    end
  end

  assign count_o    = cnt_q;
  assign ovf_o      = ovf_q;
  assign led_snap_o = led_q;

`ifdef BTN_TIMESTAMP_EN
  logic [TsW-1:0] ts_q;
  logic [TsW-1:0] tstamp_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q     <= '0;
      tstamp_q <= '0;
    end else begin
      ts_q <= ts_q + TsW'(1);
      if (evt_o) begin
        tstamp_q <= ts_q;
      end
    end
  end

  assign tstamp_o = tstamp_q;
`else
  assign tstamp_o = '0;
`endif

endmodule

// File: rtl/btn_intr_ctrl.sv
// Button interrupt controller: AXI4-Lite register file, sticky pending flag and masked irq.
// Define BTN_TIMESTAMP_EN to add the TSTAMP register at 0x10.
module btn_intr_ctrl
  import btn_intr_ctrl_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
  parameter int unsigned CNT_W              = 16,
  parameter int unsigned TS_W               = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic                            intr_src,
  input  logic [3:0]                      led_on,
  output logic                            irq,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  wr_state_e wr_q;
  rd_state_e rd_q;
  logic      awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic      pend_q, en_q, irq_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic             evt, ovf;
  logic [CNT_W-1:0] count;
  logic [3:0]       led_snap;
  logic [TS_W-1:0]  tstamp;

  logic       wr_fire, st_wr;
  logic [2:0] wr_idx, rd_idx;

  assign wr_idx  = S_AXI_AWADDR[4:2];
  assign rd_idx  = S_AXI_ARADDR[4:2];
  // Masters hold both valids until ready, so the write lands on the ready cycle.
  assign wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign st_wr   = wr_fire & (wr_idx == ADDR_STATUS) & S_AXI_WSTRB[0];

  btn_evt_cnt #(
    .CntW (CNT_W),
    .TsW  (TS_W)
  ) u_evt_cnt (
    .clk_i      (S_AXI_ACLK),
    .rst_ni     (S_AXI_ARESETN),
    .intr_src_i (intr_src),
    .led_on_i   (led_on),
    .cnt_clr_i  (wr_fire & (wr_idx == ADDR_COUNT)),
    .ovf_clr_i  (st_wr & S_AXI_WDATA[ST_OVF_BIT]),
    .evt_o      (evt),
    .count_o    (count),
    .ovf_o      (ovf),
    .led_snap_o (led_snap),
    .tstamp_o   (tstamp)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      pend_q <= 1'b0;
      en_q   <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (evt) begin
        pend_q <= 1'b1;
      end else if (st_wr && S_AXI_WDATA[ST_PEND_BIT]) begin
        pend_q <= 1'b0;
      end
      if (wr_fire && wr_idx == ADDR_ENABLE && S_AXI_WSTRB[0]) begin
        en_q <= S_AXI_WDATA[0];
      end
      irq_q <= pend_q & en_q;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wr_q      <= WrIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      case (wr_q)
        WrIdle: begin
          if (S_AXI_AWVALID && S_AXI_WVALID) begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            wr_q      <= WrAccept;
          end
        end
        WrAccept: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b1;
          wr_q      <= WrResp;
        end
        WrResp: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            wr_q     <= WrIdle;
          end
        end
        default: wr_q <= WrIdle;
      endcase
    end
  end

  always_comb begin
    rdata_d = '0;
    case (rd_idx)
      ADDR_STATUS: begin
        rdata_d[ST_PEND_BIT] = pend_q;
        rdata_d[ST_OVF_BIT]  = ovf;
      end
      ADDR_ENABLE:  rdata_d[0]         = en_q;
      ADDR_COUNT:   rdata_d[CNT_W-1:0] = count;
      ADDR_LEDSNAP: rdata_d[3:0]       = led_snap;
`ifdef BTN_TIMESTAMP_EN
      ADDR_TSTAMP:  rdata_d[TS_W-1:0]  = tstamp;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_q      <= RdIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rd_q)
        RdIdle: begin
          if (S_AXI_ARVALID) begin
            arready_q <= 1'b1;
            rd_q      <= RdAccept;
          end
        end
        RdAccept: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rdata_q   <= rdata_d;
          rd_q      <= RdResp;
        end
        RdResp: begin
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            rd_q     <= RdIdle;
          end
        end
        default: rd_q <= RdIdle;
      endcase
    end
  end

  logic unused_ins;
`ifdef BTN_TIMESTAMP_EN
  assign unused_ins = ^{S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:2], S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1],
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  assign unused_ins = ^{tstamp, S_AXI_WDATA[C_S_AXI_DATA_WIDTH-1:2],
                        S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1], S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`endif

  assign irq           = irq_q;
  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;

endmodule
